// File: rtl/shot_turn_controller_if.sv
// Signal bundle between the shot controller and the rest of the game:
// keyboard levels, ball status and the pulses/levels the controller produces.
interface shot_turn_controller_if #(
  parameter int NUM_BALLS = 4
);
  logic                 startOfFrame;
  logic                 keyUp;
  logic                 keyDown;
  logic                 keyLeft;
  logic                 keyRight;
  logic                 keyEnter;
  logic [NUM_BALLS-1:0] ballMoving;
  logic [NUM_BALLS-1:0] ballPocketed;
  logic                 chargeUp;
  logic                 chargeDown;
  logic                 chargeLeft;
  logic                 chargeRight;
  logic                 releaseBall;
  logic                 currentPlayer;
  logic [3:0]           score0;
  logic [3:0]           score1;
  logic                 foul;
  logic                 whiteRespawn;
  logic                 gameOver;
  logic [2:0]           state;

  modport master (
    output startOfFrame, keyUp, keyDown, keyLeft, keyRight, keyEnter,
           ballMoving, ballPocketed,
    input  chargeUp, chargeDown, chargeLeft, chargeRight, releaseBall,
           currentPlayer, score0, score1, foul, whiteRespawn, gameOver, state
  );

  modport slave (
    input  startOfFrame, keyUp, keyDown, keyLeft, keyRight, keyEnter,
           ballMoving, ballPocketed,
    output chargeUp, chargeDown, chargeLeft, chargeRight, releaseBall,
           currentPlayer, score0, score1, foul, whiteRespawn, gameOver, state
  );
endinterface

// File: rtl/shot_turn_controller.sv
// Shot sequencer: turns key edges into charge/release pulses, waits for the
// table to settle, then scores pockets, flags fouls and alternates players.
module shot_turn_controller #(
  parameter int NUM_BALLS     = 4,
  parameter int SETTLE_FRAMES = 8,
  parameter int MAX_CHARGE    = 8,
  parameter int AIM_TIMEOUT   = 900
) (
  input logic                    clk,
  input logic                    reset,
  shot_turn_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    AIM     = 3'd0,
    RELEASE = 3'd1,
    MOVING  = 3'd2,
    EVAL    = 3'd3,
    OVER    = 3'd4
  } state_t;

  localparam int CW = $clog2(MAX_CHARGE + 1) + 1;
  localparam int TW = $clog2(AIM_TIMEOUT + 1);
  localparam int SW = $clog2(SETTLE_FRAMES + 1);
  localparam int PW = $clog2(NUM_BALLS + 1);
  localparam logic signed [CW-1:0] CHG_MAX = CW'(MAX_CHARGE);
  localparam logic signed [CW-1:0] CHG_MIN = -CHG_MAX;
  localparam logic signed [CW-1:0] CHG_ONE = CW'(1);

  function automatic logic [PW-1:0] popcount_obj(input logic [NUM_BALLS-1:0] m);
    int c;
    c = 0;
    for (int i = 1; i < NUM_BALLS; i++) c += int'(m[i]);
    return PW'(c);
  endfunction

  function automatic logic [3:0] sat_add(input logic [3:0] a, input logic [PW-1:0] b);
    int s;
    s = int'(a) + int'(b);
    return (s > 15) ? 4'd15 : 4'(s);
  endfunction

  state_t                 state_q, state_n;
  logic [4:0]             key_q, key_now, key_rise;
  logic signed [CW-1:0]   chx_q, chx_n, chy_q, chy_n;
  logic [TW-1:0]          timer_q, timer_n;
  logic [SW-1:0]          settle_q, settle_n;
  logic [NUM_BALLS-1:0]   mask_q, mask_n;
  logic [NUM_BALLS-1:1]   cum_q, cum_n;
  logic                   player_q, player_n;
  logic [3:0]             score0_q, score0_n, score1_q, score1_n;
  logic                   up_q, up_n, dn_q, dn_n, lf_q, lf_n, rt_q, rt_n;
  logic                   rel_q, rel_n, foul_q, foul_n, resp_q, resp_n;
  logic [PW-1:0]          n_obj;

  // Key order: 0 up, 1 down, 2 left, 3 right, 4 enter
  assign key_now  = {bus.keyEnter, bus.keyRight, bus.keyLeft, bus.keyDown, bus.keyUp};
  assign key_rise = key_now & ~key_q;
  assign n_obj    = popcount_obj(mask_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= AIM;
      key_q    <= '0;
      chx_q    <= '0;
      chy_q    <= '0;
      timer_q  <= '0;
      settle_q <= '0;
      mask_q   <= '0;
      cum_q    <= '0;
      player_q <= 1'b0;
      score0_q <= '0;
      score1_q <= '0;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
      lf_q     <= 1'b0;
      rt_q     <= 1'b0;
      rel_q    <= 1'b0;
      foul_q   <= 1'b0;
      resp_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      key_q    <= key_now;
      chx_q    <= chx_n;
      chy_q    <= chy_n;
      timer_q  <= timer_n;
      settle_q <= settle_n;
      mask_q   <= mask_n;
      cum_q    <= cum_n;
      player_q <= player_n;
      score0_q <= score0_n;
      score1_q <= score1_n;
      up_q     <= up_n;
      dn_q     <= dn_n;
      lf_q     <= lf_n;
      rt_q     <= rt_n;
      rel_q    <= rel_n;
      foul_q   <= foul_n;
      resp_q   <= resp_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    chx_n    = chx_q;
    chy_n    = chy_q;
    timer_n  = timer_q;
    settle_n = settle_q;
    mask_n   = mask_q;
    player_n = player_q;
    score0_n = score0_q;
    score1_n = score1_q;
    up_n     = 1'b0;
    dn_n     = 1'b0;
    lf_n     = 1'b0;
    rt_n     = 1'b0;
    rel_n    = 1'b0;
    foul_n   = 1'b0;
    resp_n   = 1'b0;
    // Cumulative tally sees every pocket until the game ends, scored or not
    cum_n    = (state_q == OVER) ? cum_q : (cum_q | bus.ballPocketed[NUM_BALLS-1:1]);

    case (state_q)
      AIM: begin
        if (key_rise[4] && (chx_q != '0 || chy_q != '0)) begin
          state_n = RELEASE;
        end else if (bus.startOfFrame && timer_q == TW'(AIM_TIMEOUT - 1)) begin
          foul_n   = 1'b1;
          chx_n    = '0;
          chy_n    = '0;
          player_n = ~player_q;
          timer_n  = '0;
        end else begin
          if (bus.startOfFrame) timer_n = timer_q + TW'(1);
          if (key_rise[0] && !key_rise[1] && chy_q < CHG_MAX) begin
            up_n  = 1'b1;
            chy_n = chy_q + CHG_ONE;
          end
          if (key_rise[1] && !key_rise[0] && chy_q > CHG_MIN) begin
            dn_n  = 1'b1;
            chy_n = chy_q - CHG_ONE;
          end
          if (key_rise[2] && !key_rise[3] && chx_q > CHG_MIN) begin
            lf_n  = 1'b1;
            chx_n = chx_q - CHG_ONE;
          end
          if (key_rise[3] && !key_rise[2] && chx_q < CHG_MAX) begin
            rt_n  = 1'b1;
            chx_n = chx_q + CHG_ONE;
          end
        end
      end
      RELEASE: begin
        rel_n    = 1'b1;
        chx_n    = '0;
        chy_n    = '0;
        mask_n   = '0;
        settle_n = '0;
        state_n  = MOVING;
      end
      MOVING: begin
        mask_n = mask_q | bus.ballPocketed;
        if (bus.startOfFrame) begin
          if (|bus.ballMoving) begin
            settle_n = '0;
          end else begin
            settle_n = settle_q + SW'(1);
            if (settle_q == SW'(SETTLE_FRAMES - 1)) state_n = EVAL;
          end
        end
      end
      EVAL: begin
        if (player_q) score1_n = sat_add(score1_q, n_obj);
        else          score0_n = sat_add(score0_q, n_obj);
        if (mask_q[0]) begin
          foul_n   = 1'b1;
          resp_n   = 1'b1;
          player_n = ~player_q;
        end else if (n_obj == '0) begin
          player_n = ~player_q;
        end
        if (&cum_q) begin
          state_n = OVER;
        end else begin
          state_n = AIM;
          timer_n = '0;
        end
      end
      OVER: ;
      default: state_n = AIM;
    endcase
  end

  assign bus.chargeUp      = up_q;
  assign bus.chargeDown    = dn_q;
  assign bus.chargeLeft    = lf_q;
  assign bus.chargeRight   = rt_q;
  assign bus.releaseBall   = rel_q;
  assign bus.foul          = foul_q;
  assign bus.whiteRespawn  = resp_q;
  assign bus.currentPlayer = player_q;
  assign bus.score0        = score0_q;
  assign bus.score1        = score1_q;
  assign bus.gameOver      = (state_q == OVER);
  assign bus.state         = state_q;

endmodule
